// File: rtl/rst_seq_ctrl_if.sv
// Signal bundle between the reset sequencer and its surroundings: timing strobe,
// PLL lock, soft-reset handshake and the sequenced domain resets with status.
interface rst_seq_ctrl_if #(
    parameter int NDOM = 4
);
    logic            pluse_us;
    logic            pll_locked;
    logic            soft_req;
    logic            soft_ack;
    logic [NDOM-1:0] dom_rst_n;
    logic            seq_done;
    logic [2:0]      state;
    logic [7:0]      lock_lost_cnt;

    // Environment side: drives strobe, lock and soft request, observes the resets.
    modport master (
        output pluse_us, pll_locked, soft_req,
        input  soft_ack, dom_rst_n, seq_done, state, lock_lost_cnt
    );

    // Sequencer side.
    modport slave (
        input  pluse_us, pll_locked, soft_req,
        output soft_ack, dom_rst_n, seq_done, state, lock_lost_cnt
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for the clk_sys domain. Qualifies PLL lock for LOCK_US microsecond
// strobes, then releases the domain resets LSB first, STEP_US strobes apart. Lock loss
// or an accepted soft request pulls every domain back into reset; the release sequence
// then runs again. All outputs come straight from flops so dom_rst_n cannot glitch.
module rst_seq_ctrl #(
    parameter int NDOM        = 4,
    parameter int LOCK_US     = 100,
    parameter int STEP_US     = 10,
    parameter int SOFT_US     = 5,
    parameter int SYNC_STAGES = 2
) (
    input logic         clk_sys,
    input logic         rst,
    rst_seq_ctrl_if.slave sq
);

    localparam int MAX_LS  = (LOCK_US > STEP_US) ? LOCK_US : STEP_US;
    localparam int CNT_MAX = (MAX_LS > SOFT_US) ? MAX_LS : SOFT_US;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NDOM > 1) ? $clog2(NDOM) : 1;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        SOFT      = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk_s;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
    logic [NDOM-1:0]    dom_q, dom_d;
    logic               done_q, done_d;
    logic               ack_q, ack_d;
    logic [7:0]         lost_q, lost_d;
    logic               lose_evt;
    logic               start_rel;

    // Bring the asynchronous lock indication into clk_sys through a flop chain.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sq.pll_locked};
        end
    end

    assign lk_s    = sync_q[SYNC_STAGES-1];
    assign idx_inc = idx_q + IDX_W'(1);

    // Next-state and next-output decode; priority is lock loss, then soft request, then timers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        dom_d     = dom_q;
        done_d    = done_q;
        ack_d     = 1'b0;
        lost_d    = lost_q;
        lose_evt  = 1'b0;
        start_rel = 1'b0;

        // Microsecond strobes accumulate while the state holds; saturate so long
        // soft-reset holds cannot wrap the counter back below SOFT_US.
        if (sq.pluse_us && (cnt_q != CNT_W'(CNT_MAX))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            WAIT_LOCK: begin
                dom_d  = '0;
                done_d = 1'b0;
                if (lk_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                // Lock dropping before any release is not counted as a loss.
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (sq.pluse_us && (cnt_q == CNT_W'(LOCK_US - 1))) begin
                    start_rel = 1'b1;
                end
            end
            RELEASE: begin
                if (!lk_s) begin
                    lose_evt = 1'b1;
                end else if (sq.pluse_us && (cnt_q == CNT_W'(STEP_US - 1))) begin
                    cnt_d          = '0;
                    idx_d          = idx_inc;
                    dom_d[idx_inc] = 1'b1;
                    if (idx_inc == IDX_W'(NDOM - 1)) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!lk_s) begin
                    lose_evt = 1'b1;
                end else if (sq.soft_req) begin
                    state_d = SOFT;
                    cnt_d   = '0;
                    dom_d   = '0;
                    done_d  = 1'b0;
                    ack_d   = 1'b1;
                end
            end
            SOFT: begin
                // Lock is still good here, so release restarts without re-qualification.
                if (!lk_s) begin
                    lose_evt = 1'b1;
                end else if (!sq.soft_req && (cnt_q >= CNT_W'(SOFT_US))) begin
                    start_rel = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
                idx_d   = '0;
                dom_d   = '0;
                done_d  = 1'b0;
            end
        endcase

        if (start_rel) begin
            cnt_d    = '0;
            idx_d    = '0;
            dom_d    = '0;
            dom_d[0] = 1'b1;
            if (NDOM == 1) begin
                state_d = RUN;
                done_d  = 1'b1;
            end else begin
                state_d = RELEASE;
            end
        end

        if (lose_evt) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
            done_d  = 1'b0;
            if (lost_q != 8'hFF) begin
                lost_d = lost_q + 8'd1;
            end
        end
    end

    // State, timer and output registers; reset forces every domain into reset.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            lost_q  <= lost_d;
        end
    end

    assign sq.dom_rst_n     = dom_q;
    assign sq.seq_done      = done_q;
    assign sq.soft_ack      = ack_q;
    assign sq.state         = state_q;
    assign sq.lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: lock qualification, cumulative release, lock loss,
// soft-reset handshake, reset priority and loss-counter saturation.
module tb_rst_seq_ctrl;

    logic clk_sys = 1'b0;
    logic rst;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   ack_cnt = 0;

    rst_seq_ctrl_if #(.NDOM(4)) sq ();

    rst_seq_ctrl #(
        .NDOM(4), .LOCK_US(100), .STEP_US(10), .SOFT_US(5), .SYNC_STAGES(2)
    ) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .sq      (sq)
    );

    always #5 clk_sys = ~clk_sys;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_sys);
        #1;
        if (sq.soft_ack === 1'b1) ack_cnt++;
    endtask

    // n microsecond strobes, each the last cycle of a period-cycle window.
    task automatic pulses(input int n, input int period);
        for (int k = 0; k < n; k++) begin
            sq.pluse_us = 1'b0;
            repeat (period - 1) step();
            sq.pluse_us = 1'b1;
            step();
        end
        sq.pluse_us = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat [4];
        pat[0] = 4'b0001; pat[1] = 4'b0011; pat[2] = 4'b0111; pat[3] = 4'b1111;

        // 1. reset, lock qualification and cumulative release at 100 cycles per strobe
        rst = 1'b1; sq.pll_locked = 1'b0; sq.soft_req = 1'b0; sq.pluse_us = 1'b0;
        repeat (10) step();
        chk("rst_state", 32'(sq.state), 1);
        chk("rst_dom", 32'(sq.dom_rst_n), 0);
        chk("rst_done", 32'(sq.seq_done), 0);
        chk("rst_ack", 32'(sq.soft_ack), 0);
        chk("rst_lost", 32'(sq.lock_lost_cnt), 0);
        rst = 1'b0; sq.pll_locked = 1'b1;
        step(); step();
        chk("sync_lat_wait", 32'(sq.state), 1);
        step();
        chk("enter_stable", 32'(sq.state), 2);
        pulses(99, 100);
        chk("stable_hold_dom", 32'(sq.dom_rst_n), 0);
        chk("stable_hold_state", 32'(sq.state), 2);
        pulses(1, 100);
        chk("rel0_dom", 32'(sq.dom_rst_n), 32'(pat[0]));
        chk("rel0_state", 32'(sq.state), 3);
        for (int k = 1; k < 4; k++) begin
            pulses(9, 100);
            chk("rel_hold_dom", 32'(sq.dom_rst_n), 32'(pat[k-1]));
            chk("rel_hold_done", 32'(sq.seq_done), 0);
            pulses(1, 100);
            chk("rel_step_dom", 32'(sq.dom_rst_n), 32'(pat[k]));
        end
        chk("run_done", 32'(sq.seq_done), 1);
        chk("run_state", 32'(sq.state), 4);

        // 4. soft request held 800 cycles in RUN
        ack_cnt = 0;
        sq.soft_req = 1'b1;
        for (int i = 0; i < 800; i++) begin
            sq.pluse_us = ((i % 100) == 99);
            step();
            if (i == 0) begin
                chk("soft_enter_state", 32'(sq.state), 5);
                chk("soft_enter_dom", 32'(sq.dom_rst_n), 0);
                chk("soft_enter_done", 32'(sq.seq_done), 0);
            end
        end
        sq.pluse_us = 1'b0;
        chk("soft_ack_single", 32'(ack_cnt), 1);
        chk("soft_hold_dom", 32'(sq.dom_rst_n), 0);
        sq.soft_req = 1'b0;
        step();
        chk("soft_exit_dom", 32'(sq.dom_rst_n), 1);
        chk("soft_exit_state", 32'(sq.state), 3);
        pulses(29, 100);
        chk("soft_rel_hold", 32'(sq.dom_rst_n), 7);
        pulses(1, 100);
        chk("soft_rel_full", 32'(sq.dom_rst_n), 15);
        chk("soft_rel_done", 32'(sq.seq_done), 1);

        // 3. lock loss in RUN
        sq.pll_locked = 1'b0;
        repeat (3) step();
        chk("loss_run_dom", 32'(sq.dom_rst_n), 0);
        chk("loss_run_done", 32'(sq.seq_done), 0);
        chk("loss_run_lost", 32'(sq.lock_lost_cnt), 1);
        chk("loss_run_state", 32'(sq.state), 1);

        // 2. lock drop during STABLE (strobe every 10 cycles from here on)
        sq.pll_locked = 1'b1;
        repeat (3) step();
        chk("relock_stable", 32'(sq.state), 2);
        pulses(50, 10);
        sq.pll_locked = 1'b0;
        repeat (3) step();
        chk("stable_drop_state", 32'(sq.state), 1);
        chk("stable_drop_lost", 32'(sq.lock_lost_cnt), 1);
        sq.pll_locked = 1'b1;
        repeat (3) step();
        pulses(99, 10);
        chk("requal_hold_dom", 32'(sq.dom_rst_n), 0);
        pulses(1, 10);
        chk("requal_rel_dom", 32'(sq.dom_rst_n), 1);

        // 6. reset in the middle of release
        pulses(10, 10);
        chk("mid_rel_dom", 32'(sq.dom_rst_n), 3);
        rst = 1'b1;
        step();
        chk("mid_rst_state", 32'(sq.state), 1);
        chk("mid_rst_dom", 32'(sq.dom_rst_n), 0);
        chk("mid_rst_done", 32'(sq.seq_done), 0);
        chk("mid_rst_ack", 32'(sq.soft_ack), 0);
        chk("mid_rst_lost", 32'(sq.lock_lost_cnt), 0);
        rst = 1'b0;
        step(); step();
        chk("mid_rst_sync_clear", 32'(sq.state), 1);
        step();
        chk("mid_rst_stable", 32'(sq.state), 2);

        // 5. soft request raised in STABLE is only accepted on reaching RUN
        ack_cnt = 0;
        sq.soft_req = 1'b1;
        pulses(100, 10);
        chk("early_soft_rel", 32'(sq.dom_rst_n), 1);
        pulses(30, 10);
        chk("early_soft_run", 32'(sq.state), 4);
        chk("early_soft_noack", 32'(ack_cnt), 0);
        step();
        chk("early_soft_accept", 32'(sq.state), 5);
        chk("early_soft_ack", 32'(sq.soft_ack), 1);
        chk("early_soft_dom", 32'(sq.dom_rst_n), 0);
        step();
        chk("early_soft_ack_once", 32'(ack_cnt), 1);
        pulses(5, 10);
        chk("early_soft_hold", 32'(sq.state), 5);
        sq.soft_req = 1'b0;
        step();
        chk("early_soft_exit", 32'(sq.dom_rst_n), 1);
        pulses(30, 10);
        chk("early_soft_full", 32'(sq.dom_rst_n), 15);

        // 7. 300 lock losses after release began; counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            sq.pll_locked = 1'b0;
            repeat (3) step();
            if (i == 0)   chk("sat_first", 32'(sq.lock_lost_cnt), 1);
            if (i == 253) chk("sat_254", 32'(sq.lock_lost_cnt), 254);
            if (i == 254) chk("sat_255", 32'(sq.lock_lost_cnt), 255);
            sq.pll_locked = 1'b1;
            repeat (3) step();
            pulses(100, 1);
        end
        chk("sat_final", 32'(sq.lock_lost_cnt), 255);
        chk("sat_final_state", 32'(sq.state), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
